// File: rtl/snitch_hwloop_nest.sv
// Nested zero-overhead loop controller: the lowest-index loop that can still jump wins the fetch redirect.
// jump/target are combinational from pc; loop state moves only on retire, so stalls simply hold retire low.
module snitch_hwloop_nest #(
  parameter int unsigned N_LOOPS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W  = $clog2(N_LOOPS > 2 ? N_LOOPS : 2)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [1:0]         cfg_sel_i,
  input  logic [ADDR_W-1:0]  cfg_wdata_i,
  output logic [ADDR_W-1:0]  cfg_rdata_o,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               retire_i,
  input  logic               flush_i,
  output logic               jump_o,
  output logic [ADDR_W-1:0]  target_o,
  output logic [N_LOOPS-1:0] active_o,
  output logic               busy_o
);

  logic [ADDR_W-1:0]  start_q [N_LOOPS];
  logic [ADDR_W-1:0]  end_q   [N_LOOPS];
  logic [CNT_W-1:0]   cnt_q   [N_LOOPS];
  logic [CNT_W-1:0]   init_q  [N_LOOPS];
  logic [N_LOOPS-1:0] mode_q;

  logic [N_LOOPS-1:0] hit, jmp, exh;
  logic               found;

  // A loop is armed exactly when its counter is non-zero; no separate flag is kept.
  for (genvar g = 0; g < N_LOOPS; g++) begin : g_active
    assign active_o[g] = |cnt_q[g];
  end
  assign busy_o = |active_o;

  always_comb begin
    hit      = '0;
    jmp      = '0;
    exh      = '0;
    found    = 1'b0;
    jump_o   = 1'b0;
    target_o = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      hit[k] = active_o[k] && (pc_i == end_q[k]);
      if (hit[k] && !found) begin
        if (cnt_q[k] > CNT_W'(1)) begin
          jmp[k]   = 1'b1;
          found    = 1'b1;
          jump_o   = 1'b1;
          target_o = start_q[k];
        end else begin
          exh[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      if (cfg_idx_i == IDX_W'(k)) begin
        case (cfg_sel_i)
          2'd0: cfg_rdata_o = start_q[k];
          2'd1: cfg_rdata_o = end_q[k];
          2'd2: cfg_rdata_o = ADDR_W'(cnt_q[k]);
          2'd3: cfg_rdata_o = ADDR_W'(mode_q[k]);
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q <= '0;
      for (int k = 0; k < N_LOOPS; k++) begin
        start_q[k] <= '0;
        end_q[k]   <= '0;
        cnt_q[k]   <= '0;
        init_q[k]  <= '0;
      end
    end else if (flush_i) begin
      for (int k = 0; k < N_LOOPS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_LOOPS; k++) begin
        if (retire_i && jmp[k]) begin
          cnt_q[k] <= cnt_q[k] - CNT_W'(1);
        end else if (retire_i && exh[k]) begin
          cnt_q[k] <= mode_q[k] ? init_q[k] : '0;
        end
        // Config write is ordered last so it overrides a same-cycle retire update.
        if (cfg_we_i && (cfg_idx_i == IDX_W'(k))) begin
          case (cfg_sel_i)
            2'd0: start_q[k] <= cfg_wdata_i;
            2'd1: end_q[k]   <= cfg_wdata_i;
            2'd2: begin
              cnt_q[k]  <= cfg_wdata_i[CNT_W-1:0];
              init_q[k] <= cfg_wdata_i[CNT_W-1:0];
            end
            2'd3: mode_q[k]  <= cfg_wdata_i[0];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_snitch_hwloop_nest.sv
// Bench for snitch_hwloop_nest: directed loop programs followed by randomized traffic,
// all checked against a loop-context model that applies the loop rules directly.
module tb_snitch_hwloop_nest;
  localparam int N = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, cfg_we_i, retire_i, flush_i, jump_o, busy_o;
  logic [0:0]  cfg_idx_i;
  logic [1:0]  cfg_sel_i, active_o;
  logic [31:0] cfg_wdata_i, cfg_rdata_o, pc_i, target_o;

  snitch_hwloop_nest dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_sel_i(cfg_sel_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .pc_i(pc_i), .retire_i(retire_i), .flush_i(flush_i), .jump_o(jump_o),
    .target_o(target_o), .active_o(active_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_start [N];
  logic [31:0] m_end   [N];
  logic [15:0] m_cnt   [N];
  logic [15:0] m_init  [N];
  logic        m_mode  [N];
  int          hq[$];
  bit          ej;
  logic [31:0] et;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Collect armed loops whose end matches pc, innermost first; return position of the jumper.
  function automatic int m_scan(input logic [31:0] pc);
    hq.delete();
    for (int k = 0; k < N; k++)
      if (m_cnt[k] != 0 && m_end[k] == pc) hq.push_back(k);
    foreach (hq[i]) if (m_cnt[hq[i]] > 1) return i;
    return hq.size();
  endfunction

  task automatic m_update(input int jp);
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        m_start[k] = 0; m_end[k] = 0; m_cnt[k] = 0; m_init[k] = 0; m_mode[k] = 0;
      end
    end else if (flush_i) begin
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      if (retire_i) begin
        for (int i = 0; i < jp; i++) m_cnt[hq[i]] = m_mode[hq[i]] ? m_init[hq[i]] : 16'd0;
        if (jp < hq.size()) m_cnt[hq[jp]] = m_cnt[hq[jp]] - 16'd1;
      end
      if (cfg_we_i) begin
        case (cfg_sel_i)
          2'd0: m_start[cfg_idx_i] = cfg_wdata_i;
          2'd1: m_end[cfg_idx_i]   = cfg_wdata_i;
          2'd2: begin m_cnt[cfg_idx_i] = cfg_wdata_i[15:0]; m_init[cfg_idx_i] = cfg_wdata_i[15:0]; end
          2'd3: m_mode[cfg_idx_i]  = cfg_wdata_i[0];
        endcase
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1ns later, model advances at the rising edge.
  task automatic step();
    int          jp;
    logic [1:0]  ea;
    logic [31:0] er;
    #1;
    jp = m_scan(pc_i);
    ej = (jp < hq.size());
    et = ej ? m_start[hq[jp]] : 32'd0;
    for (int k = 0; k < N; k++) ea[k] = (m_cnt[k] != 0);
    case (cfg_sel_i)
      2'd0: er = m_start[cfg_idx_i];
      2'd1: er = m_end[cfg_idx_i];
      2'd2: er = {16'd0, m_cnt[cfg_idx_i]};
      default: er = {31'd0, m_mode[cfg_idx_i]};
    endcase
    chk_val("jump", jump_o, ej);
    chk_val("target", target_o, et);
    chk_val("active", active_o, ea);
    chk_val("busy", busy_o, |ea);
    chk_val("rdata", cfg_rdata_o, er);
    @(posedge clk_i);
    m_update(jp);
    @(negedge clk_i);
  endtask

  task automatic cfg(input int idx, input int sel, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_idx_i = 1'(idx); cfg_sel_i = 2'(sel); cfg_wdata_i = d; retire_i = 1'b0;
    step();
    cfg_we_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; retire_i = 1'b0; cfg_we_i = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input int idx, input int sel, input logic [31:0] exp);
    cfg_idx_i = 1'(idx); cfg_sel_i = 2'(sel);
    #1 chk_val(tag, cfg_rdata_o, exp);
  endtask

  // Execute straight-line code from 'first', following redirects, until 'exit_pc' is reached.
  task automatic exec(input logic [31:0] first, input logic [31:0] exit_pc, input logic [31:0] watch,
                      output int nwatch, output int njump);
    logic [31:0] pc;
    int n;
    pc = first; n = 0; nwatch = 0; njump = 0;
    while (pc != exit_pc && n < 200) begin
      pc_i = pc; retire_i = 1'b1;
      step();
      if (pc == watch) nwatch++;
      if (ej) njump++;
      pc = ej ? et : pc + 32'd4;
      n++;
    end
    retire_i = 1'b0;
    chk_val("exec_exit", pc, exit_pc);
  endtask

  initial begin
    int nw, nj;
    logic [31:0] prev_t;
    bit prev_j;
    for (int k = 0; k < N; k++) begin
      m_start[k] = 0; m_end[k] = 0; m_cnt[k] = 0; m_init[k] = 0; m_mode[k] = 0;
    end
    rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_sel_i = '0; cfg_wdata_i = '0;
    pc_i = '0; retire_i = 1'b0; flush_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk_val("rst_jump", jump_o, 0);
    chk_val("rst_target", target_o, 0);
    chk_val("rst_active", active_o, 0);
    chk_val("rst_busy", busy_o, 0);

    // Single loop, three iterations.
    cfg(0, 0, 32'h100); cfg(0, 1, 32'h10C); cfg(0, 2, 3);
    exec(32'h100, 32'h110, 32'h100, nw, nj);
    chk_val("t1_jumps", nj, 2);
    chk_val("t1_body", nw, 3);
    #1 chk_val("t1_active", active_o, 2'b00);

    // Nested loops sharing an end address; inner loop auto-reloads.
    do_reset();
    cfg(0, 0, 32'h200); cfg(0, 1, 32'h208); cfg(0, 2, 2); cfg(0, 3, 1);
    cfg(1, 0, 32'h1FC); cfg(1, 1, 32'h208); cfg(1, 2, 3);
    exec(32'h1FC, 32'h20C, 32'h200, nw, nj);
    chk_val("t2_inner_body", nw, 6);
    rd_chk("t2_cnt0", 0, 2, 2);
    rd_chk("t2_cnt1", 1, 2, 0);
    chk_val("t2_active", active_o, 2'b01);

    // Stall at the end address: a single decrement only on the retiring cycle.
    do_reset();
    cfg(0, 0, 32'h300); cfg(0, 1, 32'h30C); cfg(0, 2, 4);
    pc_i = 32'h30C; retire_i = 1'b0;
    repeat (5) step();
    chk_val("t3_jump_held", jump_o, 1);
    rd_chk("t3_cnt_held", 0, 2, 4);
    retire_i = 1'b1; step(); retire_i = 1'b0;
    rd_chk("t3_cnt_after", 0, 2, 3);
    step();
    rd_chk("t3_cnt_stable", 0, 2, 3);

    // Flush beats a retire at the loop end.
    do_reset();
    cfg(0, 0, 32'h400); cfg(0, 1, 32'h40C); cfg(0, 2, 5);
    pc_i = 32'h40C; retire_i = 1'b1; flush_i = 1'b1;
    step();
    flush_i = 1'b0; retire_i = 1'b0;
    #1;
    chk_val("t4_active", active_o, 0);
    chk_val("t4_jump", jump_o, 0);
    rd_chk("t4_start", 0, 0, 32'h400);
    rd_chk("t4_end", 0, 1, 32'h40C);

    // Count write collides with a retire decrement on the same loop.
    do_reset();
    cfg(0, 0, 32'h500); cfg(0, 1, 32'h50C); cfg(0, 2, 2);
    pc_i = 32'h50C; retire_i = 1'b1;
    cfg_we_i = 1'b1; cfg_idx_i = 1'b0; cfg_sel_i = 2'd2; cfg_wdata_i = 32'd7;
    step();
    cfg_we_i = 1'b0; retire_i = 1'b0;
    rd_chk("t5_cnt", 0, 2, 7);
    chk_val("t5_active", active_o[0], 1);

    // Zero count leaves the loop idle; reset mid-loop clears everything.
    do_reset();
    cfg(0, 1, 32'h600); cfg(0, 2, 0);
    pc_i = 32'h600; retire_i = 1'b1; step(); retire_i = 1'b0;
    #1 chk_val("t6_nojump", jump_o, 0);
    cfg(0, 0, 32'h5F0); cfg(0, 2, 3);
    pc_i = 32'h600; retire_i = 1'b1; step();
    rst_ni = 1'b0; retire_i = 1'b0; step(); rst_ni = 1'b1;
    #1;
    chk_val("t6_rst_jump", jump_o, 0);
    chk_val("t6_rst_target", target_o, 0);
    chk_val("t6_rst_active", active_o, 0);
    chk_val("t6_rst_busy", busy_o, 0);

    // Randomized traffic over a small address window so loops hit often.
    do_reset();
    prev_j = 1'b0; prev_t = '0;
    repeat (3000) begin
      rst_ni    = ($urandom_range(0, 199) != 0);
      flush_i   = ($urandom_range(0, 59) == 0);
      cfg_we_i  = ($urandom_range(0, 5) == 0);
      retire_i  = ($urandom_range(0, 3) != 0);
      cfg_idx_i = 1'($urandom_range(0, 1));
      cfg_sel_i = 2'($urandom_range(0, 3));
      if (cfg_sel_i == 2'd2)      cfg_wdata_i = $urandom_range(0, 4);
      else if (cfg_sel_i == 2'd3) cfg_wdata_i = $urandom;
      else                        cfg_wdata_i = 32'h1000 + 4 * $urandom_range(0, 7);
      if (prev_j && $urandom_range(0, 1) == 0) pc_i = prev_t;
      else                                     pc_i = 32'h1000 + 4 * $urandom_range(0, 7);
      step();
      prev_j = ej && retire_i; prev_t = et;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
